// File: rtl/period_loader_pkg.sv
// Shared definitions for the period loader: FSM state encodings and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package period_loader_pkg;

  // WIDTH must stay in step with the count_pulse stage this block feeds.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/period_fifo.sv
// Synchronous FIFO of period values with occupancy count.
// Latency: a pushed entry is visible at head/level the cycle after the push edge.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module period_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  // No push-through: a full FIFO rejects the push even if it pops on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks net push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/period_loader.sv
// Issues queued period values to count_pulse, one load per observed pulse.
// Latency: pulse at edge t -> lden/cnt in cycle t+1; push into idle empty FIFO -> lden after next edge.
// Backpressure: in_ready drops when the FIFO holds DEPTH entries; extra pushes are dropped.
module period_loader
  import period_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_period,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic                     repeat_last,
  input  logic                     pulse,
  output logic [WIDTH-1:0]         cnt,
  output logic                     lden,
  output logic                     running,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_d;
  logic             lden_d;
  logic             underrun_d;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;

  assign in_ready = ~full;

  period_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (in_period),
    .push      (in_valid),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next output values; the load happens on the edge that enters LOAD,
  // so cnt/lden are already valid for the whole LOAD cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt;
    lden_d     = 1'b0;
    underrun_d = underrun;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !empty) begin
          state_d    = ST_LOAD;
          pop        = 1'b1;
          cnt_d      = head;
          lden_d     = 1'b1;
          underrun_d = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pulse) begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (!empty) begin
            state_d    = ST_LOAD;
            pop        = 1'b1;
            cnt_d      = head;
            lden_d     = 1'b1;
            underrun_d = 1'b0;
          end else if (repeat_last) begin
            // Reissue: cnt already holds the last period.
            state_d    = ST_LOAD;
            lden_d     = 1'b1;
            underrun_d = 1'b0;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs; running mirrors the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      lden     <= 1'b0;
      running  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      lden     <= lden_d;
      running  <= (state_d != ST_IDLE);
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_period_loader.sv
`timescale 1ns/1ps
module tb_period_loader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_period;
  logic             in_valid;
  logic             in_ready;
  logic             enable;
  logic             repeat_last;
  logic             pulse;
  logic [WIDTH-1:0] cnt;
  logic             lden;
  logic             running;
  logic             underrun;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  period_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_period   (in_period),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enable      (enable),
    .repeat_last (repeat_last),
    .pulse       (pulse),
    .cnt         (cnt),
    .lden        (lden),
    .running     (running),
    .underrun    (underrun),
    .level       (level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending periods, last issued value, and three flags:
  // busy (a period is in flight), loading (strobe this cycle), underrun.
  int mq[$];
  int m_cnt;
  bit m_busy;
  bit m_loading;
  bit m_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt     = 0;
    m_busy    = 0;
    m_loading = 0;
    m_und     = 0;
  endtask

  // One clock edge worth of behaviour, using the inputs held across that edge.
  task automatic model_edge();
    bit push_ok;
    push_ok = in_valid && (mq.size() < DEPTH);
    if (!m_busy) begin
      if (enable && mq.size() != 0) begin
        m_cnt = mq.pop_front(); m_loading = 1; m_busy = 1; m_und = 0;
      end
    end else if (m_loading) begin
      m_loading = 0;
    end else if (pulse) begin
      if (!enable) m_busy = 0;
      else if (mq.size() != 0) begin
        m_cnt = mq.pop_front(); m_loading = 1; m_und = 0;
      end else if (repeat_last) begin
        m_loading = 1; m_und = 0;
      end else begin
        m_busy = 0; m_und = 1;
      end
    end
    if (push_ok) mq.push_back(int'(in_period));
  endtask

  task automatic check_all();
    chk("cnt",      32'(cnt),      32'(m_cnt));
    chk("lden",     32'(lden),     32'(m_loading));
    chk("running",  32'(running),  32'(m_busy));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("level",    32'(level),    32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic step(input bit v, input int p, input bit en, input bit rep, input bit pul);
    in_valid    = v;
    in_period   = p[WIDTH-1:0];
    enable      = en;
    repeat_last = rep;
    pulse       = pul;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},      32'(cnt),      32'd0);
    chk({tag, "_lden"},     32'(lden),     32'd0);
    chk({tag, "_running"},  32'(running),  32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_period = '0; enable = 0; repeat_last = 0; pulse = 0;
    model_reset();
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Three periods issued in order, one per pulse, then an underrun.
    step(1, 9, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    step(1, 5, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      repeat (3) step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
    end
    chk("s2_underrun", 32'(underrun), 32'd1);
    chk("s2_running",  32'(running),  32'd0);

    // Fill while disabled; the fifth push is dropped, then exactly four drain.
    for (int i = 0; i < 5; i++) step(1, 11 + i, 0, 0, 0);
    chk("s3_level",    32'(level),    32'd4);
    chk("s3_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
    end
    chk("s3_drained", 32'(level), 32'd0);

    // repeat_last reloads the single period after every pulse.
    step(1, 2, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 1);
    end
    chk("s4_cnt",      32'(cnt),      32'd2);
    chk("s4_level",    32'(level),    32'd0);
    chk("s4_underrun", 32'(underrun), 32'd0);
    repeat (3) step(0, 0, 0, 0, 1);

    // enable dropped during WAIT: no load at the pulse, remaining entries kept.
    step(1, 7, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("s5_lden",    32'(lden),    32'd0);
    chk("s5_running", 32'(running), 32'd0);
    chk("s5_level",   32'(level),   32'd2);
    repeat (2) step(0, 0, 0, 0, 1);

    // Full FIFO around the wrap point; push and pop on the same edge.
    step(1, 21, 0, 0, 0);
    step(1, 22, 0, 0, 0);
    step(1, 23, 1, 0, 0);
    step(1, 24, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    step(1, 30, 1, 0, 1);
    chk("s6_level", 32'(level), 32'd3);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
    end

    // Randomized traffic, including zero periods and pulses in every state.
    for (int i = 0; i < 800; i++) begin
      int p;
      p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      step($urandom_range(0, 2) != 0, p, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-stream with the FIFO populated.
    step(1, 40, 0, 0, 0);
    step(1, 41, 1, 0, 0);
    step(1, 42, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    repeat (3) step(0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
